dual_issue_queue: RTL and testbench

- Instruction buffer between the dual-fetch stage and the dual-decode stage of the two-wide RISC-V core.
- Accepts up to two instructions (with PCs) per cycle from fetch and presents up to two to decode.
- Issues slot B alongside slot A only when the pair is independent. Otherwise B is held and becomes the next cycle's slot A.
- Decouples fetch from decode stalls and is emptied on a taken branch or jump (PCSrc).

---
 rtl/dual_issue_queue.sv | 145 ++++++++++++++
 tb/tb_dual_issue_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_queue.sv
// Dual-entry instruction buffer between the two-wide fetch and decode stages.
// First-word fall-through read; slot B issues only when independent of slot A.
module dual_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic [1:0]              push_valid_i,
  input  logic [DATA_WIDTH-1:0]   InstrA_i,
  input  logic [DATA_WIDTH-1:0]   InstrB_i,
  input  logic [DATA_WIDTH-1:0]   PCA_i,
  input  logic [DATA_WIDTH-1:0]   PCB_i,
  output logic                    push_ready_o,
  output logic                    IssueA_valid_o,
  output logic                    IssueB_valid_o,
  output logic [DATA_WIDTH-1:0]   InstrA_o,
  output logic [DATA_WIDTH-1:0]   InstrB_o,
  output logic [DATA_WIDTH-1:0]   PCA_o,
  output logic [DATA_WIDTH-1:0]   PCB_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [DATA_WIDTH-1:0] instrMem [DEPTH];
  logic [DATA_WIDTH-1:0] pcMem    [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0] count;

  logic             pushReady;
  logic             pushA;
  logic             pushB;
  logic [CNT_W-1:0] pushCnt;
  logic [CNT_W-1:0] popCnt;

  logic [DATA_WIDTH-1:0] entryA;
  logic [DATA_WIDTH-1:0] entryB;
  logic [DATA_WIDTH-1:0] entryPcA;
  logic [DATA_WIDTH-1:0] entryPcB;

  logic [4:0] rdA;
  logic [4:0] rs1B;
  logic [4:0] rs2B;
  logic [6:0] opA;
  logic [6:0] opB;
  logic       rawHazard;
  logic       ctrlHazard;
  logic       memHazard;
  logic       pairHazard;

  logic issueA;
  logic issueB;

  // Push acceptance looks only at the registered count, so a same-cycle pop
  // never turns a full queue into an accepting one.
  assign pushReady = (count <= CNT_W'(DEPTH - 2));
  assign pushA     = pushReady & ~flush_i & push_valid_i[0];
  assign pushB     = pushReady & ~flush_i & push_valid_i[0] & push_valid_i[1];
  assign pushCnt   = CNT_W'(pushA) + CNT_W'(pushB);

  assign wrPtrNext = wrPtr + PTR_W'(1);
  assign rdPtrNext = rdPtr + PTR_W'(1);

  assign entryA   = instrMem[rdPtr];
  assign entryB   = instrMem[rdPtrNext];
  assign entryPcA = pcMem[rdPtr];
  assign entryPcB = pcMem[rdPtrNext];

  assign rdA  = entryA[11:7];
  assign rs1B = entryB[19:15];
  assign rs2B = entryB[24:20];
  assign opA  = entryA[6:0];
  assign opB  = entryB[6:0];

  // Register fields are compared for every opcode; false dependences only cost a cycle.
  assign rawHazard  = (rdA != 5'd0) && ((rdA == rs1B) || (rdA == rs2B));
  assign ctrlHazard = (opA == OP_BRANCH) || (opA == OP_JAL) || (opA == OP_JALR);
  assign memHazard  = ((opA == OP_LOAD) || (opA == OP_STORE)) &&
                      ((opB == OP_LOAD) || (opB == OP_STORE));
  assign pairHazard = rawHazard | ctrlHazard | memHazard;

  assign issueA = (count >= CNT_W'(1)) & ~flush_i;
  assign issueB = (count >= CNT_W'(2)) & ~flush_i & ~pairHazard;

  assign popCnt = (stall_i | flush_i) ? '0 : (CNT_W'(issueA) + CNT_W'(issueB));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i] <= NOP;
        pcMem[i]    <= '0;
      end
    end else begin
      if (pushA) begin
        instrMem[wrPtr] <= InstrA_i;
        pcMem[wrPtr]    <= PCA_i;
      end
      if (pushB) begin
        instrMem[wrPtrNext] <= InstrB_i;
        pcMem[wrPtrNext]    <= PCB_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(pushCnt);
      rdPtr <= rdPtr + PTR_W'(popCnt);
      count <= count + pushCnt - popCnt;
    end
  end

  assign push_ready_o   = pushReady;
  assign IssueA_valid_o = issueA;
  assign IssueB_valid_o = issueB;
  assign InstrA_o       = issueA ? entryA : NOP;
  assign InstrB_o       = issueB ? entryB : NOP;
  assign PCA_o          = issueA ? entryPcA : '0;
  assign PCB_o          = issueB ? entryPcB : '0;
  assign count_o        = count;

endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_dual_issue_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [1:0]    push_valid_i = 2'b00;
  logic [DW-1:0] InstrA_i = '0, InstrB_i = '0, PCA_i = '0, PCB_i = '0;
  logic          push_ready_o, IssueA_valid_o, IssueB_valid_o;
  logic [DW-1:0] InstrA_o, InstrB_o, PCA_o, PCB_o;
  logic [3:0]    count_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } entry_t;
  entry_t mq[$];

  dual_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .push_valid_i(push_valid_i), .InstrA_i(InstrA_i), .InstrB_i(InstrB_i),
    .PCA_i(PCA_i), .PCB_i(PCB_i), .push_ready_o(push_ready_o),
    .IssueA_valid_o(IssueA_valid_o), .IssueB_valid_o(IssueB_valid_o),
    .InstrA_o(InstrA_o), .InstrB_o(InstrB_o), .PCA_o(PCA_o), .PCB_o(PCB_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drivePair(input logic [1:0] v, input logic [31:0] ia, input logic [31:0] ib,
                           input logic [31:0] pa, input logic [31:0] pb);
    push_valid_i = v; InstrA_i = ia; InstrB_i = ib; PCA_i = pa; PCB_i = pb;
  endtask

  // Pairing rules for two consecutive instructions, straight from the ISA fields.
  function automatic bit hazard(input logic [31:0] a, input logic [31:0] b);
    bit isMemA, isMemB, raw, ctl;
    raw    = (a[11:7] != 0) && (a[11:7] == b[19:15] || a[11:7] == b[24:20]);
    ctl    = (a[6:0] == 7'b1100011) || (a[6:0] == 7'b1101111) || (a[6:0] == 7'b1100111);
    isMemA = (a[6:0] == 7'b0000011) || (a[6:0] == 7'b0100011);
    isMemB = (b[6:0] == 7'b0000011) || (b[6:0] == 7'b0100011);
    return raw || ctl || (isMemA && isMemB);
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0] ops [6];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 5)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #12 rst = 1'b1;
    tick();
    drivePair(2'b11, 32'h00500093, 32'h00700113, 32'h0, 32'h4);
    tick();
    drivePair(2'b00, 0, 0, 0, 0);
    total++; if (count_o !== 4'd2) begin bad++; $display("FAIL reset_pre_count got=%0d exp=2", count_o); end
    #2 rst = 1'b0;
    #1;
    total++; if (IssueA_valid_o !== 1'b0) begin bad++; $display("FAIL reset_validA got=%b exp=0", IssueA_valid_o); end
    total++; if (IssueB_valid_o !== 1'b0) begin bad++; $display("FAIL reset_validB got=%b exp=0", IssueB_valid_o); end
    total++; if (InstrA_o !== NOP) begin bad++; $display("FAIL reset_instrA got=%h exp=%h", InstrA_o, NOP); end
    total++; if (PCA_o !== 32'h0) begin bad++; $display("FAIL reset_pcA got=%h exp=0", PCA_o); end
    total++; if (push_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", push_ready_o); end
    total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_independent();
    drivePair(2'b11, 32'h00500093, 32'h00700113, 32'h0, 32'h4);
    @(negedge clk);
    total++; if (IssueA_valid_o !== 1'b0) begin bad++; $display("FAIL indep_latency got=%b exp=0", IssueA_valid_o); end
    tick();
    drivePair(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    total++; if ({IssueA_valid_o, IssueB_valid_o} !== 2'b11) begin bad++; $display("FAIL indep_valids got=%b exp=11", {IssueA_valid_o, IssueB_valid_o}); end
    total++; if (InstrA_o !== 32'h00500093 || InstrB_o !== 32'h00700113) begin bad++; $display("FAIL indep_instr got=%h/%h exp=00500093/00700113", InstrA_o, InstrB_o); end
    total++; if (PCA_o !== 32'h0 || PCB_o !== 32'h4) begin bad++; $display("FAIL indep_pc got=%h/%h exp=0/4", PCA_o, PCB_o); end
    tick();
    @(negedge clk);
    total++; if (count_o !== 4'd0 || IssueA_valid_o !== 1'b0) begin bad++; $display("FAIL indep_drain got=%0d/%b exp=0/0", count_o, IssueA_valid_o); end
    tick();
  endtask

  task automatic test_raw_hold();
    drivePair(2'b11, 32'h00500093, 32'h001081B3, 32'h0, 32'h4);
    tick();
    drivePair(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    total++; if ({IssueA_valid_o, IssueB_valid_o} !== 2'b10) begin bad++; $display("FAIL raw_valids got=%b exp=10", {IssueA_valid_o, IssueB_valid_o}); end
    total++; if (InstrB_o !== NOP || PCB_o !== 32'h0) begin bad++; $display("FAIL raw_slotB got=%h/%h exp=%h/0", InstrB_o, PCB_o, NOP); end
    tick();
    @(negedge clk);
    total++; if (InstrA_o !== 32'h001081B3 || PCA_o !== 32'h4) begin bad++; $display("FAIL raw_next got=%h/%h exp=001081b3/4", InstrA_o, PCA_o); end
    total++; if (count_o !== 4'd1) begin bad++; $display("FAIL raw_count got=%0d exp=1", count_o); end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [31:0] got[$];
    int k;
    bit acc;
    stall_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      drivePair(2'b11, NOP | (32'(2*p) << 20), NOP | (32'(2*p+1) << 20), 32'h100 + 32'(8*p), 32'h104 + 32'(8*p));
      tick();
    end
    drivePair(2'b11, NOP, NOP, 32'h200, 32'h204);
    @(negedge clk);
    total++; if (count_o !== 4'd8 || push_ready_o !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=8/0", count_o, push_ready_o); end
    tick();
    @(negedge clk);
    total++; if (count_o !== 4'd8 || PCA_o !== 32'h100) begin bad++; $display("FAIL full_reject got=%0d/%h exp=8/100", count_o, PCA_o); end
    tick();
    stall_i = 1'b0;
    k = 4;
    for (int cyc = 0; cyc < 40 && (k < 8 || count_o != 0); cyc++) begin
      if (k < 8) drivePair(2'b11, NOP | (32'(2*k) << 20), NOP | (32'(2*k+1) << 20), 32'h100 + 32'(8*k), 32'h104 + 32'(8*k));
      else drivePair(2'b00, 0, 0, 0, 0);
      @(negedge clk);
      if (IssueA_valid_o) got.push_back(PCA_o);
      if (IssueB_valid_o) got.push_back(PCB_o);
      acc = push_ready_o && (k < 8);
      tick();
      if (acc) k++;
    end
    drivePair(2'b00, 0, 0, 0, 0);
    total++; if (got.size() != 16) begin bad++; $display("FAIL wrap_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      total++; if (got[i] !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, got[i], 32'h100 + 32'(4*i)); end
    end
  endtask

  task automatic test_flush();
    stall_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drivePair(2'b11, 32'h00500093, 32'h00700113, 32'h300 + 32'(8*p), 32'h304 + 32'(8*p));
      tick();
    end
    drivePair(2'b11, 32'h00500093, 32'h00700113, 32'h400, 32'h404);
    flush_i = 1'b1;
    @(negedge clk);
    total++; if (count_o !== 4'd6) begin bad++; $display("FAIL flush_pre got=%0d exp=6", count_o); end
    total++; if ({IssueA_valid_o, IssueB_valid_o} !== 2'b00 || InstrA_o !== NOP) begin bad++; $display("FAIL flush_outputs got=%b/%h exp=00/%h", {IssueA_valid_o, IssueB_valid_o}, InstrA_o, NOP); end
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    drivePair(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (count_o !== 4'd0 || IssueA_valid_o !== 1'b0) begin bad++; $display("FAIL flush_post got=%0d/%b exp=0/0", count_o, IssueA_valid_o); end
    tick();
  endtask

  task automatic test_control_pair();
    drivePair(2'b11, 32'h00000463, 32'h00700113, 32'h40, 32'h44);
    tick();
    drivePair(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    total++; if ({IssueA_valid_o, IssueB_valid_o} !== 2'b10 || InstrA_o !== 32'h00000463) begin bad++; $display("FAIL ctrl_pair got=%b/%h exp=10/00000463", {IssueA_valid_o, IssueB_valid_o}, InstrA_o); end
    tick();
    @(negedge clk);
    total++; if (InstrA_o !== 32'h00700113 || PCA_o !== 32'h44) begin bad++; $display("FAIL ctrl_next got=%h/%h exp=00700113/44", InstrA_o, PCA_o); end
    tick();
    drivePair(2'b11, 32'h00052283, 32'h0065a023, 32'h80, 32'h84);
    tick();
    drivePair(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    total++; if ({IssueA_valid_o, IssueB_valid_o} !== 2'b10) begin bad++; $display("FAIL mem_pair got=%b exp=10", {IssueA_valid_o, IssueB_valid_o}); end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [1:0] pv;
    logic [31:0] ia, ib, pc;
    bit expA, expB, ready;
    int npop;
    logic [31:0] eIA, eIB, ePA, ePB;
    mq.delete();
    pc = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 2))
        0: pv = 2'b00;
        1: pv = 2'b01;
        default: pv = 2'b11;
      endcase
      ia = randInstr(); ib = randInstr();
      drivePair(pv, ia, ib, pc, pc + 4);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      ready = (DEPTH - mq.size()) >= 2;
      expA  = (mq.size() >= 1) && !flush_i;
      expB  = (mq.size() >= 2) && !flush_i && !hazard(mq[0].instr, mq[1].instr);
      eIA = expA ? mq[0].instr : NOP; ePA = expA ? mq[0].pc : 32'h0;
      eIB = expB ? mq[1].instr : NOP; ePB = expB ? mq[1].pc : 32'h0;
      total++;
      if ({IssueA_valid_o, IssueB_valid_o, push_ready_o, count_o} !== {expA, expB, ready, 4'(mq.size())}) begin
        bad++; $display("FAIL rand_status cyc=%0d got=%b%b%b/%0d exp=%b%b%b/%0d", cyc, IssueA_valid_o, IssueB_valid_o, push_ready_o, count_o, expA, expB, ready, mq.size());
      end
      total++;
      if ({InstrA_o, PCA_o} !== {eIA, ePA}) begin
        bad++; $display("FAIL rand_slotA cyc=%0d got=%h/%h exp=%h/%h", cyc, InstrA_o, PCA_o, eIA, ePA);
      end
      total++;
      if ({InstrB_o, PCB_o} !== {eIB, ePB}) begin
        bad++; $display("FAIL rand_slotB cyc=%0d got=%h/%h exp=%h/%h", cyc, InstrB_o, PCB_o, eIB, ePB);
      end
      if (flush_i) mq.delete();
      else begin
        npop = stall_i ? 0 : (int'(expA) + int'(expB));
        for (int i = 0; i < npop; i++) void'(mq.pop_front());
        if (ready && pv[0]) begin
          mq.push_back('{instr: ia, pc: pc});
          if (pv[1]) mq.push_back('{instr: ib, pc: pc + 4});
          pc = pc + 8;
        end
      end
      tick();
    end
    flush_i = 1'b0; stall_i = 1'b0;
    drivePair(2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_hold();
    test_full_wrap();
    test_flush();
    test_control_pair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
